// File: rtl/alu_pkg.sv
// Shared definitions for the ALU bus sequencer: opcodes, wide-op decode, FSM states.
package alu_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_OP_W   = 5;
    localparam int unsigned STATE_W    = 3;

    localparam logic [DEF_OP_W-1:0] OP_AND = 5'd0;
    localparam logic [DEF_OP_W-1:0] OP_OR  = 5'd1;
    localparam logic [DEF_OP_W-1:0] OP_XOR = 5'd2;
    localparam logic [DEF_OP_W-1:0] OP_ADD = 5'd3;
    localparam logic [DEF_OP_W-1:0] OP_SUB = 5'd4;
    localparam logic [DEF_OP_W-1:0] OP_MUL = 5'd5;
    localparam logic [DEF_OP_W-1:0] OP_DIV = 5'd6;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        OUT_LO = 3'd4,
        OUT_HI = 3'd5
    } state_t;

    // Wide ops produce a meaningful high word and emit a second result beat.
    function automatic logic is_wide_op(input logic [DEF_OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_z_capture.sv
// Result capture: ZLO/ZHI registers and zero/negative flags, loaded in EXEC.
// Ports:
//   clock, clear_n       clock and synchronous active-low reset
//   load                 capture enable (EXEC cycle, not aborted)
//   wide                 current op returns a 64-bit result
//   z_lo_in, z_hi_in     combinational ALU result words
//   z_lo, z_hi           captured result words
//   flag_zero, flag_neg  flags of the captured result
module alu_z_capture #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              load,
    input  logic              wide,
    input  logic [DATA_W-1:0] z_lo_in,
    input  logic [DATA_W-1:0] z_hi_in,
    output logic [DATA_W-1:0] z_lo,
    output logic [DATA_W-1:0] z_hi,
    output logic              flag_zero,
    output logic              flag_neg
);

    logic [DATA_W-1:0] z_hi_d;
    logic              zero_d;
    logic              neg_d;

    // Narrow ops discard whatever the ALU drives on its high word.
    always_comb begin
        z_hi_d = wide ? z_hi_in : '0;
        zero_d = wide ? ((z_hi_in == '0) && (z_lo_in == '0)) : (z_lo_in == '0);
        neg_d  = wide ? z_hi_in[DATA_W-1] : z_lo_in[DATA_W-1];
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            z_lo      <= '0;
            z_hi      <= '0;
            flag_zero <= 1'b0;
            flag_neg  <= 1'b0;
        end else if (load) begin
            z_lo      <= z_lo_in;
            z_hi      <= z_hi_d;
            flag_zero <= zero_d;
            flag_neg  <= neg_d;
        end
    end

endmodule

// File: rtl/alu_bus_sequencer.sv
// Single-bus operand/result sequencer around a combinational ALU.
// Loads operand A then B from the shared bus, runs one EXEC cycle, then
// returns ZLO (and ZHI for wide ops) on a valid/ready result port.
// Ports:
//   clock, clear_n            clock and synchronous active-low reset
//   start, op, abort          op request (IDLE only), opcode, cancel
//   bus_in, bus_valid         shared operand bus
//   alu_a, alu_b, alu_op      ALU operands and latched opcode
//   alu_z_lo, alu_z_hi        ALU result words
//   z_out, z_valid, z_ready   result beat handshake
//   z_flag_zero, z_flag_neg   captured result flags
//   busy, done                activity and completion pulse
module alu_bus_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned OP_W   = DEF_OP_W
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic              abort,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              bus_valid,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_z_lo,
    input  logic [DATA_W-1:0] alu_z_hi,
    output logic [DATA_W-1:0] z_out,
    output logic              z_valid,
    input  logic              z_ready,
    output logic              z_flag_zero,
    output logic              z_flag_neg,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            next_state;
    logic              z_valid_next;
    logic              busy_next;
    logic              done_next;
    logic              wide;
    logic              cap_load;
    logic [DATA_W-1:0] z_lo;
    logic [DATA_W-1:0] z_hi;

    assign wide     = is_wide_op(DEF_OP_W'(alu_op));
    assign cap_load = (state == EXEC) && !abort;

    // State and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state   <= IDLE;
            z_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= next_state;
            z_valid <= z_valid_next;
            busy    <= busy_next;
            done    <= done_next;
        end
    end

    // Next-state: abort overrides every non-IDLE transition.
    always_comb begin
        next_state = state;
        if (abort && (state != IDLE)) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)     next_state = LOAD_A;
                LOAD_A:  if (bus_valid) next_state = LOAD_B;
                LOAD_B:  if (bus_valid) next_state = EXEC;
                EXEC:                   next_state = OUT_LO;
                OUT_LO:  if (z_ready)   next_state = wide ? OUT_HI : IDLE;
                OUT_HI:  if (z_ready)   next_state = IDLE;
                default:                next_state = IDLE;
            endcase
        end
    end

    // Outputs for the coming cycle; done marks a delivered final beat only.
    always_comb begin
        z_valid_next = (next_state == OUT_LO) || (next_state == OUT_HI);
        busy_next    = (next_state != IDLE);
        done_next    = !abort && z_ready &&
                       ((state == OUT_HI) || ((state == OUT_LO) && !wide));
    end

    // Operand/opcode latches and the result beat register.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            z_out  <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                alu_op <= op;
            end
            if ((state == LOAD_A) && bus_valid && !abort) begin
                alu_a <= bus_in;
            end
            if ((state == LOAD_B) && bus_valid && !abort) begin
                alu_b <= bus_in;
            end
            // z_out is preloaded with the low word so it is valid on OUT_LO entry.
            if (cap_load) begin
                z_out <= alu_z_lo;
            end else if ((state == OUT_LO) && z_ready && wide && !abort) begin
                z_out <= z_hi;
            end
        end
    end

    alu_z_capture #(
        .DATA_W(DATA_W)
    ) u_z_capture (
        .clock    (clock),
        .clear_n  (clear_n),
        .load     (cap_load),
        .wide     (wide),
        .z_lo_in  (alu_z_lo),
        .z_hi_in  (alu_z_hi),
        .z_lo     (z_lo),
        .z_hi     (z_hi),
        .flag_zero(z_flag_zero),
        .flag_neg (z_flag_neg)
    );

    // ZLO is consumed via the z_out preload; keep it for visibility.
    logic unused_z_lo;
    assign unused_z_lo = ^z_lo;

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// Self-checking bench for alu_bus_sequencer with a behavioural ALU and result model.
module tb_alu_bus_sequencer;
    import alu_pkg::*;

    logic        clock;
    logic        clear_n;
    logic        start;
    logic [4:0]  op;
    logic        abort;
    logic [31:0] bus_in;
    logic        bus_valid;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic [31:0] alu_z_lo;
    logic [31:0] alu_z_hi;
    logic [31:0] z_out;
    logic        z_valid;
    logic        z_ready;
    logic        z_flag_zero;
    logic        z_flag_neg;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    alu_bus_sequencer dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .start      (start),
        .op         (op),
        .abort      (abort),
        .bus_in     (bus_in),
        .bus_valid  (bus_valid),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_z_lo   (alu_z_lo),
        .alu_z_hi   (alu_z_hi),
        .z_out      (z_out),
        .z_valid    (z_valid),
        .z_ready    (z_ready),
        .z_flag_zero(z_flag_zero),
        .z_flag_neg (z_flag_neg),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Architectural result {hi, lo}; narrow ops have hi = 0.
    function automatic logic [63:0] ref_result(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            OP_AND: return {32'd0, a & b};
            OP_OR:  return {32'd0, a | b};
            OP_XOR: return {32'd0, a ^ b};
            OP_ADD: return {32'd0, a + b};
            OP_SUB: return {32'd0, a - b};
            OP_MUL: return 64'(a) * 64'(b);
            OP_DIV: return (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: return 64'd0;
        endcase
    endfunction

    // ALU stand-in: narrow ops drive junk on the high word, which must be discarded.
    logic [63:0] stub_r;
    always_comb begin
        stub_r = ref_result(alu_op, alu_a, alu_b);
        alu_z_lo = stub_r[31:0];
        alu_z_hi = ((alu_op == OP_MUL) || (alu_op == OP_DIV)) ? stub_r[63:32] : (~stub_r[31:0] ^ 32'h5A5A_0F0F);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one full operation and checks every cycle of it; ends in the done cycle.
    task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int gap_a, input int gap_b, input int stall);
        logic [63:0] r;
        logic        w;
        logic [31:0] beats [2];
        int          nb;
        r = ref_result(o, a, b);
        w = (o == OP_MUL) || (o == OP_DIV);
        beats[0] = r[31:0];
        beats[1] = r[63:32];
        nb = w ? 2 : 1;

        start = 1'b1; op = o; tick();
        start = 1'b0; op = 5'($urandom);
        checks++;
        if (busy !== 1'b1 || alu_op !== o) begin
            failures++;
            $display("FAIL start_latch busy=%b alu_op=%0d expected busy=1 alu_op=%0d", busy, alu_op, o);
        end
        for (int i = 0; i < gap_a; i++) begin
            bus_in = $urandom; bus_valid = 1'b0; start = 1'($urandom); tick();
        end
        start = 1'b0;
        bus_in = a; bus_valid = 1'b1; tick();
        bus_valid = 1'b0; bus_in = $urandom;
        checks++;
        if (alu_a !== a || busy !== 1'b1) begin
            failures++;
            $display("FAIL load_a alu_a=%h busy=%b expected %h busy=1", alu_a, busy, a);
        end
        for (int i = 0; i < gap_b; i++) begin
            bus_in = $urandom; bus_valid = 1'b0; tick();
        end
        bus_in = b; bus_valid = 1'b1; tick();
        bus_valid = 1'b0; bus_in = $urandom;
        checks++;
        if (alu_b !== b || z_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL load_b alu_b=%h z_valid=%b expected %h z_valid=0", alu_b, z_valid, b);
        end
        tick();
        checks++;
        if (z_flag_zero !== (r == 64'd0) || z_flag_neg !== (w ? r[63] : r[31]) ||
            alu_op !== o || alu_a !== a || alu_b !== b) begin
            failures++;
            $display("FAIL flags zero=%b neg=%b op=%0d expected zero=%b neg=%b op=%0d",
                     z_flag_zero, z_flag_neg, alu_op, (r == 64'd0), (w ? r[63] : r[31]), o);
        end
        for (int k = 0; k < nb; k++) begin
            for (int s = 0; s < stall; s++) begin
                z_ready = 1'b0;
                checks++;
                if (z_valid !== 1'b1 || z_out !== beats[k] || done !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_beat%0d z_valid=%b z_out=%h done=%b expected 1 %h 0",
                             k, z_valid, z_out, done, beats[k]);
                end
                tick();
            end
            z_ready = 1'b1;
            checks++;
            if (z_valid !== 1'b1 || z_out !== beats[k] || done !== 1'b0) begin
                failures++;
                $display("FAIL beat%0d z_valid=%b z_out=%h done=%b expected 1 %h 0",
                         k, z_valid, z_out, done, beats[k]);
            end
            tick();
            z_ready = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || z_valid !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse done=%b busy=%b z_valid=%b expected 1 0 0", done, busy, z_valid);
        end
    endtask

    task automatic test_reset();
        clear_n = 1'b0; tick(); tick();
        clear_n = 1'b1;
        checks++;
        if (alu_a !== 0 || alu_b !== 0 || alu_op !== 0 || z_out !== 0 || z_valid !== 0 ||
            z_flag_zero !== 0 || z_flag_neg !== 0 || busy !== 0 || done !== 0) begin
            failures++;
            $display("FAIL reset a=%h b=%h op=%0d z=%h v=%b fz=%b fn=%b busy=%b done=%b expected all 0",
                     alu_a, alu_b, alu_op, z_out, z_valid, z_flag_zero, z_flag_neg, busy, done);
        end
    endtask

    task automatic test_and();
        run_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0, 0);
        tick();
        checks++;
        if (done !== 1'b0 || z_out !== 32'h00F0_1234 || z_flag_zero !== 1'b0 || z_flag_neg !== 1'b0) begin
            failures++;
            $display("FAIL and_after done=%b z_out=%h zero=%b neg=%b expected 0 00f01234 0 0",
                     done, z_out, z_flag_zero, z_flag_neg);
        end
    endtask

    task automatic test_mul();
        run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 0, 0, 0);
        tick();
        checks++;
        if (z_out !== 32'h0000_0001 || z_flag_zero !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mul_after z_out=%h zero=%b done=%b expected 00000001 0 0", z_out, z_flag_zero, done);
        end
    endtask

    task automatic test_backpressure();
        run_op(OP_ADD, $urandom, $urandom, 0, 0, 5);
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL bp_single_done done=%b expected 0", done);
        end
    endtask

    task automatic test_bus_gaps();
        logic [31:0] a_before;
        a_before = alu_a;
        for (int i = 0; i < 3; i++) begin
            bus_in = $urandom | 32'h1; bus_valid = 1'b1; tick();
        end
        bus_valid = 1'b0;
        checks++;
        if (alu_a !== a_before || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_bus alu_a=%h busy=%b expected %h 0", alu_a, busy, a_before);
        end
        run_op(OP_SUB, 32'd5, 32'd5, 2, 3, 0);
        tick();
        checks++;
        if (z_out !== 32'd0 || z_flag_zero !== 1'b1) begin
            failures++;
            $display("FAIL sub_zero z_out=%h zero=%b expected 0 1", z_out, z_flag_zero);
        end
    endtask

    task automatic test_abort();
        // Abort while waiting for operand B.
        start = 1'b1; op = OP_ADD; tick();
        start = 1'b0; bus_in = 32'd1; bus_valid = 1'b1; tick();
        bus_valid = 1'b0; abort = 1'b1; tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || z_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_load_b busy=%b z_valid=%b done=%b expected 0 0 0", busy, z_valid, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_load_b_late done=%b busy=%b expected 0 0", done, busy);
        end
        // Abort on the final OUT_HI handshake: 0x8000_0000 * 4 = 0x2_0000_0000.
        start = 1'b1; op = OP_MUL; tick();
        start = 1'b0; bus_in = 32'h8000_0000; bus_valid = 1'b1; tick();
        bus_in = 32'd4; tick();
        bus_valid = 1'b0; tick();
        z_ready = 1'b1; tick();
        checks++;
        if (z_valid !== 1'b1 || z_out !== 32'd2) begin
            failures++;
            $display("FAIL abort_out_hi_pre z_valid=%b z_out=%h expected 1 00000002", z_valid, z_out);
        end
        abort = 1'b1; tick();
        abort = 1'b0; z_ready = 1'b0;
        checks++;
        if (z_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || z_flag_zero !== 1'b0 || z_flag_neg !== 1'b0) begin
            failures++;
            $display("FAIL abort_out_hi v=%b busy=%b done=%b zero=%b neg=%b expected 0 0 0 0 0",
                     z_valid, busy, done, z_flag_zero, z_flag_neg);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL abort_out_hi_late done=%b expected 0", done);
        end
        run_op(OP_XOR, $urandom, $urandom, 1, 0, 1);
        tick();
    endtask

    task automatic test_reset_mid();
        start = 1'b1; op = OP_OR; tick();
        start = 1'b0; bus_in = 32'hDEAD_BEEF; bus_valid = 1'b1; tick();
        bus_in = 32'h1234_5678; tick();
        bus_valid = 1'b0;
        clear_n = 1'b0; tick();
        clear_n = 1'b1;
        checks++;
        if (alu_a !== 0 || alu_b !== 0 || alu_op !== 0 || z_out !== 0 || z_valid !== 0 ||
            z_flag_zero !== 0 || z_flag_neg !== 0 || busy !== 0 || done !== 0) begin
            failures++;
            $display("FAIL reset_exec a=%h b=%h op=%0d z=%h v=%b busy=%b done=%b expected all 0",
                     alu_a, alu_b, alu_op, z_out, z_valid, busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_exec_late done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        run_op(OP_ADD, $urandom, $urandom, 0, 0, 0);
        run_op(OP_MUL, $urandom, $urandom, 0, 0, 0);
        run_op(OP_DIV, $urandom, $urandom_range(1, 1000), 0, 0, 1);
        run_op(OP_AND, $urandom, $urandom, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        logic [4:0] ops [7];
        logic [31:0] a;
        logic [31:0] b;
        ops = '{OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_MUL, OP_DIV};
        for (int n = 0; n < 30; n++) begin
            a = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            run_op(ops[$urandom_range(0, 6)], a, b, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
    endtask

    initial begin
        checks = 0; failures = 0;
        clear_n = 1'b0; start = 1'b0; op = 5'd0; abort = 1'b0;
        bus_in = 32'd0; bus_valid = 1'b0; z_ready = 1'b0;
        test_reset();
        test_and();
        test_mul();
        test_backpressure();
        test_bus_gaps();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
